serial_rx_package: RTL and testbench
====================================

SERIAL_RX_PACKAGE -- requirements
Module: serial_rx_package

Interface
REQ-001 Parameter AddressWidth, default 2: log2 of the number of words per package.
REQ-002 Parameter WordWidth, default 8: data bits per serial word.
REQ-003 Parameter SerialTimerWidth, default 3: bit period P = 2**SerialTimerWidth enabled cycles.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port ce, input, 1: clock enable; when low, state, timer, shift register and address hold.
REQ-007 Port rx, input, 1: serial line, idle high.
REQ-008 Port data, output, 2**AddressWidth*WordWidth: last complete package.
REQ-009 Port valid, output, 1: one-cycle pulse, package complete.
REQ-010 Port err, output, 1: one-cycle pulse, framing error.
REQ-011 Port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-012 Two-flop synchronizer on rx, clocked every cycle regardless of ce; FSM uses only the synchronized value rxs.
REQ-013 Frame format: 1 start bit (0), WordWidth data bits LSB first, 1 stop bit (1); matches SerialTXPackage framing.
REQ-014 FSM states: IDLE, START, DATA, STOP; all transitions and timer counts occur only on cycles with ce=1.
REQ-015 IDLE: rxs=0 -> START, timer cleared.
REQ-016 START: after P/2 enabled cycles sample rxs; 0 -> DATA with timer cleared, 1 -> IDLE (glitch rejected, no err).
REQ-017 DATA: every P enabled cycles sample rxs into the shift register; after WordWidth samples -> STOP.
REQ-018 STOP: after P enabled cycles sample rxs; 1 -> store word at current address, then IDLE; 0 -> err pulse, address cleared to 0, partial package discarded, then IDLE.
REQ-019 Word k (address k) occupies data[(k+1)*WordWidth-1 : k*WordWidth]; first word received lands in the LSBs.
REQ-020 Address counter is AddressWidth bits and increments on each good stop bit, wrapping from 2**AddressWidth-1 to 0.
REQ-021 On the good stop bit of address 2**AddressWidth-1: data updated with the full package and valid=1 in the cycle after the stop sample, irrespective of ce.
REQ-022 data changes only on package completion; partial packages never appear on data.
REQ-023 valid and err never assert in the same cycle; each lasts exactly one clk cycle.
REQ-024 rx falling edge during STOP before its sample is ignored; a new start is detected only in IDLE.

Reset
REQ-025 rst=1 at a clk edge: state IDLE, timer 0, address 0, shift register 0, data 0, valid 0, err 0, busy 0, synchronizer flops 1.
REQ-026 rst has priority over ce and over a mid-frame reception; the interrupted word and package are discarded.

Structure
REQ-027 Shared include file holds the FSM state encodings and the P/2 and P timer terminal-count expressions, also used by SerialTXPackage.
REQ-028 One sub-module, serial_rx_word: synchronizer, FSM and shift register for a single word, with word-done and frame-error strobes; the top holds the address counter and package register.

Verification (AddressWidth=2, WordWidth=8, SerialTimerWidth=3, P=8, ce=1 unless stated)
REQ-029 Loopback from SerialTXPackage sending 32'h12345678 -> exactly one valid pulse, data=32'h12345678, err never high, busy low after the last stop bit.
REQ-030 rx low for 2 cycles in IDLE -> busy high for at most 6 cycles then low, no valid, no err, address unchanged.
REQ-031 Second word sent with stop bit 0 -> one err pulse, address back to 0; following good 4-word package 32'hA5A5_0F0F -> valid and data=32'hA5A50F0F.
REQ-032 rst pulsed mid-way through word 2 -> all outputs 0 next cycle; subsequent package 32'hDEADBEEF received correctly.
REQ-033 ce toggled 1/0 every cycle with transmitter bit period doubled to 16 cycles -> package 32'hCAFE0001 received correctly, valid one cycle wide.

Source files
------------

// File: rtl/serial_rx_package_pkg.sv
// Shared definitions for the serial package receiver (and its transmitter
// counterpart): FSM state encodings and the bit-timer terminal counts.
//   half_tc(tw) : timer value on the enabled cycle that completes P/2
//   full_tc(tw) : timer value on the enabled cycle that completes P
// where P = 2**tw enabled clock cycles per serial bit.
package serial_rx_package_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic int half_tc(input int tw);
    return ((1 << tw) / 2) - 1;
  endfunction

  function automatic int full_tc(input int tw);
    return (1 << tw) - 1;
  endfunction

endpackage

// File: rtl/serial_rx_package_word.sv
// serial_rx_word: receives one UART-style word (start 0, LSB-first data,
// stop 1) from an asynchronous line.
//   clk, rst   : clock, synchronous active-high reset
//   ce         : clock enable for FSM, timer and shift register
//   rx         : raw serial line (idle high)
//   word       : shift register contents (valid when word_done is high)
//   word_done  : combinational strobe, good stop bit sampled this cycle
//   frame_err  : combinational strobe, bad stop bit sampled this cycle
//   busy       : FSM not idle
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | line idle, waiting for rxs low
// ST_START | waiting P/2 to re-check the start bit mid-bit
// ST_DATA  | sampling WordWidth data bits every P
// ST_STOP  | waiting P to sample the stop bit
module serial_rx_word
  import serial_rx_package_pkg::*;
#(
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 rx,
  output logic [WordWidth-1:0] word,
  output logic                 word_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BitCountWidth = (WordWidth > 1) ? $clog2(WordWidth) : 1;
  localparam logic [SerialTimerWidth-1:0] HalfTc =
    SerialTimerWidth'(half_tc(SerialTimerWidth));
  localparam logic [SerialTimerWidth-1:0] FullTc =
    SerialTimerWidth'(full_tc(SerialTimerWidth));
  localparam logic [BitCountWidth-1:0] LastBit = BitCountWidth'(WordWidth - 1);

  logic [1:0]                  sync_q;
  logic                        rxs;
  rx_state_e                   state, state_nxt;
  logic [SerialTimerWidth-1:0] timer, timer_nxt;
  logic [BitCountWidth-1:0]    bit_cnt, bit_cnt_nxt;
  logic [WordWidth-1:0]        shreg, shreg_nxt;

  assign rxs  = sync_q[1];
  assign word = shreg;
  assign busy = (state != ST_IDLE);

  // Synchronizer runs every cycle; only the FSM side honours ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state   <= ST_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    word_done   = 1'b0;
    frame_err   = 1'b0;
    if (ce) begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state_nxt = ST_START;
            timer_nxt = '0;
          end
        end
        ST_START: begin
          if (timer == HalfTc) begin
            timer_nxt   = '0;
            bit_cnt_nxt = '0;
            // A start bit that is gone by mid-bit was a glitch.
            state_nxt   = rxs ? ST_IDLE : ST_DATA;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == FullTc) begin
            timer_nxt = '0;
            // LSB first: shift right, new bit enters at the MSB.
            shreg_nxt = shreg >> 1;
            shreg_nxt[WordWidth-1] = rxs;
            if (bit_cnt == LastBit) state_nxt = ST_STOP;
            else bit_cnt_nxt = bit_cnt + 1'b1;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        ST_STOP: begin
          if (timer == FullTc) begin
            timer_nxt = '0;
            state_nxt = ST_IDLE;
            if (rxs) word_done = 1'b1;
            else frame_err = 1'b1;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx_package.sv
// serial_rx_package: assembles 2**AddressWidth serial words into a package.
//   clk, rst : clock, synchronous active-high reset
//   ce       : clock enable for the receive path
//   rx       : serial line (idle high)
//   data     : last complete package, word k at data[k*WordWidth +: WordWidth]
//   valid    : one-cycle pulse when data is updated
//   err      : one-cycle pulse on a framing error (package restarts at word 0)
//   busy     : receiver FSM not idle
module serial_rx_package
  import serial_rx_package_pkg::*;
#(
  parameter int AddressWidth     = 2,
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ce,
  input  logic                                   rx,
  output logic [(2**AddressWidth)*WordWidth-1:0] data,
  output logic                                   valid,
  output logic                                   err,
  output logic                                   busy
);

  localparam int PkgWidth = (2**AddressWidth) * WordWidth;

  logic [WordWidth-1:0]    word;
  logic                    word_done;
  logic                    frame_err;
  logic [AddressWidth-1:0] addr;
  logic [PkgWidth-1:0]     pkg_buf, pkg_nxt;

  serial_rx_word #(
    .WordWidth        (WordWidth),
    .SerialTimerWidth (SerialTimerWidth)
  ) u_word (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .rx        (rx),
    .word      (word),
    .word_done (word_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Staging buffer with the incoming word merged in; data only ever gets a
  // full copy of it, so partial packages stay invisible.
  always_comb begin
    pkg_nxt = pkg_buf;
    pkg_nxt[addr*WordWidth +: WordWidth] = word;
  end

  // Strobes from the word receiver only fire with ce=1, so valid/err drop
  // the following cycle regardless of ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      pkg_buf <= '0;
      data    <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (word_done) begin
        pkg_buf <= pkg_nxt;
        addr    <= addr + 1'b1;
        if (addr == '1) begin
          data  <= pkg_nxt;
          valid <= 1'b1;
        end
      end else if (frame_err) begin
        addr <= '0;
        err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_package.sv
// Self-checking bench for serial_rx_package: a behavioural transmitter drives
// rx, expected packages go into a queue and are popped on each valid pulse.
module tb_serial_rx_package;

  localparam int AW = 2;
  localparam int WW = 8;
  localparam int TW = 3;
  localparam int P  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] data;
  logic        valid;
  logic        err;
  logic        busy;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          valid_seen = 0;
  int          err_seen   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  bit          valid_prev = 1'b0;
  bit          ce_toggle  = 1'b0;

  always #5 clk = ~clk;

  serial_rx_package #(
    .AddressWidth     (AW),
    .WordWidth        (WW),
    .SerialTimerWidth (TW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .rx    (rx),
    .data  (data),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  always @(negedge clk) begin
    if (ce_toggle) ce = ~ce;
    else ce = 1'b1;
  end

  // Scoreboard / pulse monitor
  always @(negedge clk) begin
    if (valid) begin
      valid_seen++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_valid: data=%h, no package expected", data);
      end else begin
        exp_v = exp_q.pop_front();
        if (data !== exp_v) $display("FAIL package_data: got %h expected %h", data, exp_v);
        else pass_cnt++;
      end
    end
    if (err) err_seen++;
    if (valid || err) begin
      total_cnt++;
      if (valid && err) $display("FAIL valid_err_overlap: valid=%b err=%b expected not both", valid, err);
      else pass_cnt++;
    end
    if (valid_prev) begin
      total_cnt++;
      if (valid !== 1'b0) $display("FAIL valid_width: valid=%b on 2nd cycle expected 0", valid);
      else pass_cnt++;
    end
    valid_prev = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_word(input logic [7:0] w, input logic stop_bit, input int per);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = w[i];
      repeat (per) @(negedge clk);
    end
    rx = stop_bit;
    repeat (per) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_pkg(input logic [31:0] p, input int per);
    exp_q.push_back(p);
    for (int k = 0; k < 4; k++) send_word(p[k*8 +: 8], 1'b1, per);
    rx = 1'b1;
    repeat (per) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d packages pending expected 0", name, exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic check_count(input string name, input int got, input int want);
    total_cnt++;
    if (got !== want) $display("FAIL %s: got %0d expected %0d", name, got, want);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt += 4;
    if (data !== 32'h0) $display("FAIL reset_data: got %h expected 0", data); else pass_cnt++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else pass_cnt++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_pkg(32'h12345678, P);
    wait_drain(200, "loopback");
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL loopback_busy: got %b expected 0", busy); else pass_cnt++;
    check_count("loopback_valid_count", valid_seen - v0, 1);
    check_count("loopback_err_count", err_seen - e0, 0);
  endtask

  task automatic test_glitch();
    int v0, e0, busy_cnt;
    v0 = valid_seen; e0 = err_seen; busy_cnt = 0;
    exp_q.push_back(32'h44332211);
    send_word(8'h11, 1'b1, P);
    repeat (P) @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    total_cnt++;
    if (busy_cnt < 1 || busy_cnt > 6)
      $display("FAIL glitch_busy_cycles: got %0d expected 1..6", busy_cnt);
    else pass_cnt++;
    check_count("glitch_valid_count", valid_seen - v0, 0);
    check_count("glitch_err_count", err_seen - e0, 0);
    send_word(8'h22, 1'b1, P);
    send_word(8'h33, 1'b1, P);
    send_word(8'h44, 1'b1, P);
    repeat (P) @(negedge clk);
    wait_drain(200, "glitch");
    check_count("glitch_pkg_valid_count", valid_seen - v0, 1);
  endtask

  task automatic test_frame_error();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_word(8'h5A, 1'b1, P);
    send_word(8'h3C, 1'b0, P);
    rx = 1'b1;
    repeat (3*P) @(negedge clk);
    check_count("frame_err_count", err_seen - e0, 1);
    check_count("frame_err_no_valid", valid_seen - v0, 0);
    send_pkg(32'hA5A50F0F, P);
    wait_drain(200, "frame_err");
    check_count("frame_err_recovery_valid", valid_seen - v0, 1);
    check_count("frame_err_total_err", err_seen - e0, 1);
  endtask

  task automatic test_reset_mid();
    int v0;
    v0 = valid_seen;
    send_word(8'h99, 1'b1, P);
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (P) @(negedge clk);
    end
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    total_cnt += 4;
    if (data !== 32'h0) $display("FAIL rst_mid_data: got %h expected 0", data); else pass_cnt++;
    if (valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", valid); else pass_cnt++;
    if (err !== 1'b0) $display("FAIL rst_mid_err: got %b expected 0", err); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else pass_cnt++;
    rst = 1'b0;
    repeat (2*P) @(negedge clk);
    send_pkg(32'hDEADBEEF, P);
    wait_drain(200, "rst_mid");
    check_count("rst_mid_valid_count", valid_seen - v0, 1);
  endtask

  task automatic test_ce_toggle();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    ce_toggle = 1'b1;
    repeat (4) @(negedge clk);
    send_pkg(32'hCAFE0001, 2*P);
    wait_drain(400, "ce_toggle");
    repeat (4) @(negedge clk);
    ce_toggle = 1'b0;
    repeat (2) @(negedge clk);
    check_count("ce_toggle_valid_count", valid_seen - v0, 1);
    check_count("ce_toggle_err_count", err_seen - e0, 0);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    test_ce_toggle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
